// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad lock session controller.
package lock_pkg;

  localparam int unsigned TIMER_W = 24;

  localparam logic [3:0] KEY_CANCEL = 4'hA;
  localparam logic [3:0] KEY_LOCK   = 4'hB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_LOCKOUT
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; expired pulses so the owner acts exactly N cycles after a load of N.
module lock_timer
  import lock_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expired
);

  logic [TIMER_W-1:0] cnt;

  // Loading N-1 with a registered pulse on the 1->0 step lands the pulse
  // in the cycle before edge N, so the FSM reacts on edge N itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (load) begin
      cnt     <= load_val - TIMER_W'(1);
      expired <= 1'b0;
    end else if (cnt != '0) begin
      cnt     <= cnt - TIMER_W'(1);
      expired <= (cnt == TIMER_W'(1));
    end else begin
      expired <= 1'b0;
    end
  end

endmodule

// File: rtl/lock_sequencer.sv
// Keypad lock session controller: frames digit entry, forwards digits to the
// matcher, and sequences unlock window, inter-key timeout and failure lockout.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned MAX_FAILS   = 3,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned UNLOCK_CYC  = 2000,
  parameter int unsigned LOCKOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_val,
  input  logic       key_valid,
  output logic [3:0] m_key_val,
  output logic       m_key_valid,
  output logic       m_clear,
  input  logic       m_result_valid,
  input  logic       m_match,
  output logic       unlocked,
  output logic       locked_out,
  output logic       busy,
  output logic [2:0] fail_count
);

  localparam logic [TIMER_W-1:0] TMO_LD   = TIMER_W'(TIMEOUT_CYC);
  localparam logic [TIMER_W-1:0] UNL_LD   = TIMER_W'(UNLOCK_CYC);
  localparam logic [TIMER_W-1:0] LCK_LD   = TIMER_W'(LOCKOUT_CYC);
  localparam logic [3:0]         DIG_LAST = 4'(DIGITS - 1);
  localparam logic [2:0]         FAIL_MAX = 3'(MAX_FAILS);

  state_t             state;
  logic [3:0]         dig_cnt;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_exp;

  logic       key_digit;
  logic       key_cancel;
  logic       key_lock;
  logic       verdict_ok;
  logic       verdict_bad;
  logic [2:0] fail_next;
  logic       lockout_next;

  assign key_digit  = key_valid && is_digit(key_val);
  assign key_cancel = key_valid && (key_val == KEY_CANCEL);
  assign key_lock   = key_valid && (key_val == KEY_LOCK);

  // A verdict on the expiry cycle takes priority over the timeout.
  assign verdict_ok   = m_result_valid && m_match;
  assign verdict_bad  = (m_result_valid && !m_match) || (!m_result_valid && tmr_exp);
  assign fail_next    = (fail_count >= FAIL_MAX) ? fail_count : fail_count + 3'd1;
  assign lockout_next = (fail_next == FAIL_MAX);

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TMO_LD;
    case (state)
      ST_IDLE, ST_ENTRY: begin
        if (key_digit) tmr_load = 1'b1;
      end
      ST_CHECK: begin
        if (verdict_ok) begin
          tmr_load = 1'b1;
          tmr_val  = UNL_LD;
        end else if (verdict_bad && lockout_next) begin
          tmr_load = 1'b1;
          tmr_val  = LCK_LD;
        end
      end
      default: ;
    endcase
  end

  lock_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  // Status outputs change only on transitions, so each one is updated in the
  // branch that leaves or enters the state it decodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      dig_cnt     <= '0;
      m_key_val   <= '0;
      m_key_valid <= 1'b0;
      m_clear     <= 1'b0;
      unlocked    <= 1'b0;
      locked_out  <= 1'b0;
      busy        <= 1'b0;
      fail_count  <= '0;
    end else begin
      m_key_valid <= 1'b0;
      m_clear     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (key_digit) begin
            m_key_val   <= key_val;
            m_key_valid <= 1'b1;
            dig_cnt     <= 4'd1;
            busy        <= 1'b1;
            state       <= ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          if (key_digit) begin
            m_key_val   <= key_val;
            m_key_valid <= 1'b1;
            dig_cnt     <= dig_cnt + 4'd1;
            if (dig_cnt == DIG_LAST) state <= ST_CHECK;
          end else if (key_cancel || tmr_exp) begin
            m_clear <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          if (verdict_ok) begin
            fail_count <= '0;
            busy       <= 1'b0;
            unlocked   <= 1'b1;
            state      <= ST_OPEN;
          end else if (verdict_bad) begin
            fail_count <= fail_next;
            m_clear    <= 1'b1;
            busy       <= 1'b0;
            if (lockout_next) begin
              locked_out <= 1'b1;
              state      <= ST_LOCKOUT;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_OPEN: begin
          if (tmr_exp || key_lock) begin
            unlocked <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_LOCKOUT: begin
          if (tmr_exp) begin
            fail_count <= '0;
            locked_out <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          busy       <= 1'b0;
          unlocked   <= 1'b0;
          locked_out <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// Scoreboard bench for lock_sequencer: a deadline-based session model predicts
// forwarded digits, clears and per-cycle status; a monitor compares them.
module tb_lock_sequencer;

  localparam int DIGITS    = 4;
  localparam int MAX_FAILS = 3;
  localparam int TMO       = 20;
  localparam int UNL       = 30;
  localparam int LCK       = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_val = '0;
  logic       key_valid = 1'b0;
  logic       m_result_valid = 1'b0;
  logic       m_match = 1'b0;
  logic [3:0] m_key_val;
  logic       m_key_valid;
  logic       m_clear;
  logic       unlocked;
  logic       locked_out;
  logic       busy;
  logic [2:0] fail_count;

  lock_sequencer #(
    .DIGITS      (DIGITS),
    .MAX_FAILS   (MAX_FAILS),
    .TIMEOUT_CYC (TMO),
    .UNLOCK_CYC  (UNL),
    .LOCKOUT_CYC (LCK)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .key_val        (key_val),
    .key_valid      (key_valid),
    .m_key_val      (m_key_val),
    .m_key_valid    (m_key_valid),
    .m_clear        (m_clear),
    .m_result_valid (m_result_valid),
    .m_match        (m_match),
    .unlocked       (unlocked),
    .locked_out     (locked_out),
    .busy           (busy),
    .fail_count     (fail_count)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int checks = 0;
  int passed = 0;

  typedef struct { int cyc; int val; } key_ev_t;
  typedef struct { int cyc; bit u; bit l; bit b; int fc; } stat_t;
  key_ev_t key_q[$];
  int      clr_q[$];
  stat_t   st_q[$];
  bit      mon_en = 1'b0;

  // Reference model: session mode, digits entered and an absolute deadline edge.
  string md = "IDLE";
  int    n_dig = 0;
  int    deadline = 0;
  int    fails = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
  endtask

  task automatic model(int k, bit kv, logic [3:0] kc, bit rv, bit rm);
    bit dig;
    dig = kv && (kc <= 4'd9);
    if (md == "IDLE") begin
      if (dig) begin
        key_q.push_back('{k, int'(kc)});
        n_dig = 1;
        deadline = k + TMO;
        md = "ENTRY";
      end
    end else if (md == "ENTRY") begin
      if (dig) begin
        key_q.push_back('{k, int'(kc)});
        n_dig++;
        deadline = k + TMO;
        if (n_dig == DIGITS) md = "CHECK";
      end else if ((kv && kc == 4'hA) || k == deadline) begin
        clr_q.push_back(k);
        md = "IDLE";
      end
    end else if (md == "CHECK") begin
      if (rv && rm) begin
        fails = 0;
        deadline = k + UNL;
        md = "OPEN";
      end else if (rv || k == deadline) begin
        if (fails < MAX_FAILS) fails++;
        clr_q.push_back(k);
        if (fails == MAX_FAILS) begin
          deadline = k + LCK;
          md = "LOCKOUT";
        end else md = "IDLE";
      end
    end else if (md == "OPEN") begin
      if (k == deadline || (kv && kc == 4'hB)) md = "IDLE";
    end else if (md == "LOCKOUT") begin
      if (k == deadline) begin
        fails = 0;
        md = "IDLE";
      end
    end
  endtask

  // Called half a cycle before an edge; drives that edge and returns after it.
  task automatic step(bit kv, logic [3:0] kc, bit rv, bit rm);
    int k;
    k = edge_n + 1;
    key_valid = kv;
    key_val = kc;
    m_result_valid = rv;
    m_match = rm;
    model(k, kv, kc, rv, rm);
    st_q.push_back('{k, md == "OPEN", md == "LOCKOUT", md == "ENTRY" || md == "CHECK", fails});
    @(negedge clk);
    #1;
    key_valid = 1'b0;
    m_result_valid = 1'b0;
  endtask

  task automatic keyp(logic [3:0] v);
    step(1'b1, v, 1'b0, 1'b0);
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic verdict(bit m);
    step(1'b0, 4'h0, 1'b1, m);
  endtask

  task automatic rand_digits(int n);
    repeat (n) keyp(4'($urandom_range(0, 9)));
  endtask

  task automatic apply_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_outputs", {m_key_val, m_key_valid, m_clear, unlocked, locked_out, busy, fail_count}, 0);
    key_q.delete();
    clr_q.delete();
    st_q.delete();
    md = "IDLE";
    n_dig = 0;
    fails = 0;
    deadline = 0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (st_q.size() == 0) check("status_queue", 0, 1);
      else begin
        stat_t s;
        s = st_q.pop_front();
        check("status_edge", edge_n, s.cyc);
        check("status", {unlocked, locked_out, busy, fail_count}, {s.u, s.l, s.b, 3'(s.fc)});
      end
      if (m_key_valid) begin
        if (key_q.size() == 0) check("spurious_key", int'(m_key_valid), 0);
        else begin
          key_ev_t e;
          e = key_q.pop_front();
          check("key_edge", edge_n, e.cyc);
          check("key_val", int'(m_key_val), e.val);
        end
      end else if (key_q.size() != 0 && key_q[0].cyc <= edge_n) begin
        void'(key_q.pop_front());
        check("key_strobe", int'(m_key_valid), 1);
      end
      if (m_clear) begin
        if (clr_q.size() == 0) check("spurious_clear", int'(m_clear), 0);
        else check("clear_edge", edge_n, clr_q.pop_front());
      end else if (clr_q.size() != 0 && clr_q[0] <= edge_n) begin
        void'(clr_q.pop_front());
        check("clear_pulse", int'(m_clear), 1);
      end
    end
  end

  initial begin
    #2 rst = 1'b1;
    @(negedge clk);
    #1;
    apply_reset();

    // Correct entry, then the full unlock window.
    for (int d = 1; d <= 4; d++) begin
      keyp(4'(d));
      idle(2);
    end
    verdict(1'b1);
    idle(33);

    // Three wrong attempts into lockout; keys during lockout are dropped.
    repeat (3) begin
      rand_digits(4);
      idle(1);
      verdict(1'b0);
      idle(2);
    end
    keyp(4'h5);
    idle(3);
    keyp(4'hA);
    keyp(4'hB);
    idle(50);

    // Inter-key timeout, then cancel.
    keyp(4'h5);
    keyp(4'h6);
    idle(21);
    keyp(4'h7);
    keyp(4'h8);
    keyp(4'hA);
    idle(3);

    // Relock from OPEN on edge 10 of the window; digits there are ignored.
    rand_digits(4);
    verdict(1'b1);
    idle(4);
    keyp(4'h3);
    idle(4);
    keyp(4'hB);
    idle(3);

    // Verdict timeout counts as a failure; a verdict on the expiry edge wins.
    rand_digits(4);
    idle(20);
    idle(2);
    rand_digits(4);
    idle(19);
    verdict(1'b1);
    idle(32);

    // Reset mid-entry and mid-lockout.
    keyp(4'h1);
    keyp(4'h2);
    apply_reset();
    rand_digits(3);
    idle(3);
    keyp(4'h9);
    idle(2);
    verdict(1'b0);
    repeat (2) begin
      rand_digits(4);
      verdict(1'b0);
    end
    idle(10);
    apply_reset();
    idle(3);

    // Randomized sessions.
    repeat (3000) begin
      bit kv;
      bit rv;
      logic [3:0] kc;
      kv = ($urandom_range(0, 3) == 0);
      kc = $urandom_range(0, 1) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
      rv = (md == "CHECK") ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 31) == 0);
      step(kv, kc, rv, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 63) == 0) idle(TMO + 2);
      if ($urandom_range(0, 999) == 0) apply_reset();
    end

    idle(2);
    check("key_queue_drained", key_q.size(), 0);
    check("clear_queue_drained", clr_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/lock_sequencer.md
# lock_sequencer

Session controller for the keypad lock. Sits between the debounced keypad decoder (`key_val`/`key_valid`) and the password-compare datapath. Frames key presses into fixed-length entry attempts and forwards digits to the matcher. Collects the match verdict, then sequences the unlock hold window, inter-key timeout, failed-attempt counting and timed lockout.

## Interface
Parameters:
- DIGITS, 4: digits per attempt (2..8)
- MAX_FAILS, 3: consecutive failures that trigger lockout (1..7)
- TIMEOUT_CYC, 1000: idle cycles allowed between keys in ENTRY, and the verdict wait limit in CHECK
- UNLOCK_CYC, 2000: cycles `unlocked` is held
- LOCKOUT_CYC, 5000: cycles `locked_out` is held

All cycle parameters are ≥2 and <2^24.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- key_val  in  4  key code from keypad decoder
- key_valid  in  1  one-cycle strobe, key_val valid
- m_key_val  out  4  digit forwarded to matcher
- m_key_valid  out  1  one-cycle strobe for m_key_val
- m_clear  out  1  one-cycle pulse: matcher discards partial entry
- m_result_valid  in  1  matcher verdict strobe
- m_match  in  1  verdict, 1 = password correct (sampled with m_result_valid)
- unlocked  out  1  lock open
- locked_out  out  1  lockout active, keypad ignored
- busy  out  1  attempt in progress (ENTRY or CHECK)
- fail_count  out  3  consecutive failed attempts

## Operation
- Key codes:
  - 0x0–0x9 are digits.
  - 0xA (KEY_CANCEL) aborts entry.
  - 0xB (KEY_LOCK) relocks from OPEN.
  - 0xC–0xF are ignored in all states.
- States IDLE, ENTRY, CHECK, OPEN, LOCKOUT. Reset state is IDLE.
- IDLE: a digit is forwarded and the block moves to ENTRY with digit count 1. Other codes are ignored.
- ENTRY:
  - Each digit is forwarded, the count increments and the timer reloads TIMEOUT_CYC.
  - When the count reaches DIGITS, the block moves to CHECK and the timer loads TIMEOUT_CYC.
  - KEY_CANCEL: m_clear, go to IDLE. fail_count is unchanged.
  - Timer expiry: m_clear, go to IDLE. fail_count is unchanged.
- CHECK: all keys are dropped.
  - m_result_valid with m_match=1: fail_count←0, go to OPEN, timer loads UNLOCK_CYC.
  - m_match=0, or timer expiry with no verdict: this is a failure.
    - fail_count increments.
    - If the new value equals MAX_FAILS, go to LOCKOUT and the timer loads LOCKOUT_CYC.
    - Otherwise go to IDLE.
    - m_clear pulses in both cases.
- OPEN: `unlocked`=1. On timer expiry or KEY_LOCK, go to IDLE. Digits are ignored.
- LOCKOUT: `locked_out`=1 and all keys are dropped. On timer expiry, fail_count←0 and go to IDLE.
- m_result_valid outside CHECK is ignored.
- Simultaneous events:
  - In ENTRY, a key on the expiry cycle wins over the timeout.
  - In CHECK, a verdict on the expiry cycle wins over the timeout.

## Timing
- Reset values: all outputs are 0, fail_count=0, state IDLE, timer 0.
- m_key_val/m_key_valid are registered, 1 cycle after the key_valid cycle.
- State changes take effect on the edge that samples the triggering event.
- unlocked, locked_out and busy are registered decodes of the state, visible the cycle after that edge.
- m_clear is asserted for exactly one cycle, the cycle after the aborting or failing event.
- Exactly DIGITS m_key_valid strobes precede each CHECK. No strobe is issued in CHECK, OPEN or LOCKOUT.
- Timer is a single 24-bit down-counter; it expires when it reaches 0 after load N, i.e. N cycles after the load edge.
- fail_count saturates at MAX_FAILS and never wraps.
- Asserting rst mid-operation returns to the reset values immediately. No m_clear is generated, because the matcher shares rst.

## Structure
- Shared package `lock_pkg` holds:
  - the state enum
  - key-code constants KEY_CANCEL=4'hA and KEY_LOCK=4'hB
  - TIMER_W=24
- One sub-module `lock_timer`: loadable down-counter with `load`, `load_val[TIMER_W-1:0]` and a registered `expired` pulse. The FSM and the digit counter stay in `lock_sequencer`.

## Test plan
Bench parameters: DIGITS=4, MAX_FAILS=3, TIMEOUT_CYC=20, UNLOCK_CYC=30, LOCKOUT_CYC=50.

- Keys 1,2,3,4 spaced 3 cycles, verdict match=1 → four m_key_valid strobes carrying 1,2,3,4; busy high through CHECK; unlocked=1 for 30 cycles, then 0; fail_count=0.
- Three 4-digit attempts, each answered match=0 → fail_count goes 1, 2, 3; locked_out=1 for 50 cycles; keys during lockout produce no m_key_valid; afterwards fail_count=0 and state IDLE.
- Keys 5,6, then 21 idle cycles → m_clear pulse, busy=0, fail_count unchanged. Keys 7,8 then 0xA → m_clear, back to IDLE.
- OPEN entered, KEY_LOCK at cycle 10 → unlocked drops the next cycle. Digit keys during OPEN produce no m_key_valid.
- CHECK with no verdict for 20 cycles → counted as a failure (fail_count+1, m_clear). A verdict on the expiry cycle is honoured instead.
- rst asserted in ENTRY after 2 digits, and separately in LOCKOUT → all outputs 0 asynchronously. The next attempt needs a full 4 digits.
